// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared bounds, fill-width helper and overlap mode type for the pattern detector
package seqdet_pkg;
   localparam int PAT_W_MIN = 2;
   localparam int PAT_W_MAX = 32;
   typedef enum logic {SEQDET_NONOVERLAP = 1'b0, SEQDET_OVERLAP = 1'b1} seqdet_overlap_e;
   function automatic int fill_width(input int pat_w);
      return (pat_w <= 2) ? 1 : $clog2(pat_w);
   endfunction
endpackage

// File: rtl/seqdet_sat_counter.sv
// seqdet_sat_counter: saturating up-counter with sync clear (wins over inc) and async active-low reset
module seqdet_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   input  logic [W-1:0] limit,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or negedge reset)
      if (!reset) count <= '0;
      else if (clear) count <= '0;
      else if (inc && count != limit) count <= count + 1'b1;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: maskable PAT_W-bit serial pattern detector with Mealy and registered match.
// Define SEQDET_COUNT_EN to add the saturating match_count output.
module seq_detector_param
   import seqdet_pkg::*;
#(
   parameter int PAT_W   = 4,
   parameter int OVERLAP = 1,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               in_valid,
   input  logic               in,
   input  logic [PAT_W-1:0]   pattern,
   input  logic [PAT_W-1:0]   mask,
   output logic               match,
`ifdef SEQDET_COUNT_EN
   output logic [COUNT_W-1:0] match_count,
`endif
   output logic               match_q
);
   localparam int FW = fill_width(PAT_W);
   localparam seqdet_overlap_e MODE = (OVERLAP != 0) ? SEQDET_OVERLAP : SEQDET_NONOVERLAP;
   localparam logic [FW-1:0] FULL = FW'(PAT_W - 1);

   if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX || COUNT_W < 1) begin : g_bad_param
      $error("seq_detector_param: illegal PAT_W or COUNT_W");
   end

   logic [PAT_W-2:0] hist;
   logic [FW-1:0]    fill;
   logic             accept;
   logic             drop;

   assign accept = in_valid & ~clear;
   assign match  = accept & (fill == FULL) & ((({hist, in} ^ pattern) & mask) == '0);
   // non-overlapping mode restarts the history count so the next match needs PAT_W fresh bits
   assign drop   = match & (MODE == SEQDET_NONOVERLAP);

   seqdet_sat_counter #(.W(FW)) u_fill (
      .clk   (clk),
      .reset (reset),
      .clear (clear | drop),
      .inc   (accept),
      .limit (FULL),
      .count (fill)
   );

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         hist    <= '0;
         match_q <= 1'b0;
      end else begin
         match_q <= match;
         if (clear) hist <= '0;
         else if (in_valid) hist <= (PAT_W - 1)'({hist, in});
      end

`ifdef SEQDET_COUNT_EN
   seqdet_sat_counter #(.W(COUNT_W)) u_count (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .inc   (match),
      .limit ({COUNT_W{1'b1}}),
      .count (match_count)
   );
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: scoreboard bench for overlapping and non-overlapping detector instances
module tb_seq_detector_param;
   localparam int PW = 4;

   logic clk = 1'b0;
   logic reset, clear, in_valid, in;
   logic [PW-1:0] pattern, mask;
   logic m_ov, m_no, q_ov, q_no;
`ifdef SEQDET_COUNT_EN
   logic [1:0] c_ov, c_no;
`endif

   always #5 clk = ~clk;

   seq_detector_param #(.PAT_W(PW), .OVERLAP(1), .COUNT_W(2)) u_ov (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in(in),
      .pattern(pattern), .mask(mask), .match(m_ov),
`ifdef SEQDET_COUNT_EN
      .match_count(c_ov),
`endif
      .match_q(q_ov)
   );

   seq_detector_param #(.PAT_W(PW), .OVERLAP(0), .COUNT_W(2)) u_no (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in(in),
      .pattern(pattern), .mask(mask), .match(m_no),
`ifdef SEQDET_COUNT_EN
      .match_count(c_no),
`endif
      .match_q(q_no)
   );

   typedef struct {
      logic       m_ov, m_no, q_ov, q_no;
      logic [1:0] c_ov, c_no;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   // reference model: windows of accepted bits since the last restart
   bit win_ov[$];
   bit win_no[$];
   logic pq_ov = 0, pq_no = 0;
   logic [1:0] cnt_ov = 0, cnt_no = 0;

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit hit(input bit w[$], input bit b);
      bit bj;
      if (w.size() < PW - 1) return 0;
      for (int j = 0; j < PW; j++) begin
         bj = (j == 0) ? b : w[w.size() - j];
         if (mask[j] && bj != pattern[j]) return 0;
      end
      return 1;
   endfunction

   task automatic step(input logic r, input logic c, input logic v, input logic b,
                       input logic [PW-1:0] p, input logic [PW-1:0] m);
      exp_t e;
      @(posedge clk);
      #1;
      reset = r; clear = c; in_valid = v; in = b; pattern = p; mask = m;
      e.m_ov = r && v && !c && hit(win_ov, b);
      e.m_no = r && v && !c && hit(win_no, b);
      e.q_ov = r ? pq_ov : 1'b0;
      e.q_no = r ? pq_no : 1'b0;
      e.c_ov = r ? cnt_ov : 2'd0;
      e.c_no = r ? cnt_no : 2'd0;
      sb.push_back(e);
      if (!r || c) begin
         win_ov.delete(); win_no.delete();
         pq_ov = 0; pq_no = 0; cnt_ov = 0; cnt_no = 0;
      end else begin
         pq_ov = e.m_ov; pq_no = e.m_no;
         if (v) begin
            win_ov.push_back(b); win_no.push_back(b);
            if (e.m_no) win_no.delete();
            while (win_ov.size() > PW - 1) void'(win_ov.pop_front());
            while (win_no.size() > PW - 1) void'(win_no.pop_front());
         end
         cnt_ov = (cnt_ov == 2'd3) ? 2'd3 : cnt_ov + 2'(e.m_ov);
         cnt_no = (cnt_no == 2'd3) ? 2'd3 : cnt_no + 2'(e.m_no);
      end
   endtask

   task automatic stream(input logic [15:0] bits, input int n, input logic [PW-1:0] p, input logic [PW-1:0] m);
      for (int i = n - 1; i >= 0; i--) step(1, 0, 1, bits[i], p, m);
   endtask

   always @(negedge clk)
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("match_ov", 2'(m_ov), 2'(e.m_ov));
         chk("match_no", 2'(m_no), 2'(e.m_no));
         chk("match_q_ov", 2'(q_ov), 2'(e.q_ov));
         chk("match_q_no", 2'(q_no), 2'(e.q_no));
`ifdef SEQDET_COUNT_EN
         chk("count_ov", c_ov, e.c_ov);
         chk("count_no", c_no, e.c_no);
`endif
      end

   initial begin
      reset = 0; clear = 0; in_valid = 0; in = 0; pattern = '0; mask = '0;
      step(0, 0, 1, 1, 4'b1011, 4'hF);
      step(0, 0, 1, 1, 4'b1011, 4'hF);
      // 1,0,1,1,0,1,1 : overlap matches on bits 4 and 7, non-overlap only on bit 4
      stream(16'b1011011, 7, 4'b1011, 4'hF);
      step(1, 1, 0, 0, 4'b1011, 4'b1001);
      stream(16'b1101, 4, 4'b1011, 4'b1001);
      step(1, 1, 0, 0, 4'b1011, 4'hF);
      stream(16'b10, 2, 4'b1011, 4'hF);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 4'b1011, 4'hF);
      stream(16'b11, 2, 4'b1011, 4'hF);
      step(1, 1, 0, 0, 4'b1011, 4'hF);
      stream(16'b101, 3, 4'b1011, 4'hF);
      step(1, 1, 1, 1, 4'b1011, 4'hF);
      stream(16'b1011, 4, 4'b1011, 4'hF);
      step(1, 1, 0, 0, 4'b0000, 4'b0000);
      stream(16'b0110100, 7, 4'b0000, 4'b0000);
      step(1, 1, 0, 0, 4'b1111, 4'hF);
      stream(16'b1111111111, 10, 4'b1111, 4'hF);
      // asynchronous reset in the middle of a cycle clears the registered outputs at once
      @(negedge clk);
      #1;
      reset = 0;
      #1;
      chk("async_rst_match_q", 2'(q_ov), 2'd0);
      chk("async_rst_match", 2'(m_ov), 2'd0);
`ifdef SEQDET_COUNT_EN
      chk("async_rst_count", c_ov, 2'd0);
`endif
      step(0, 0, 1, 1, 4'b1111, 4'hF);
      stream(16'b1111, 4, 4'b1111, 4'hF);
      for (int i = 0; i < 400; i++) begin
         int sel;
         logic [PW-1:0] p, m;
         sel = $urandom_range(0, 99);
         p = pattern; m = mask;
         if (sel < 3) step(0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, p, m);
         else if (sel < 8) step(1, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, p, m);
         else if (sel < 14) begin
            p = PW'($urandom);
            m = ($urandom_range(0, 3) == 0) ? PW'($urandom) : '1;
            step(1, 0, 0, $urandom_range(0, 1) == 1, p, m);
         end else step(1, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, p, m);
      end
      step(1, 0, 0, 0, pattern, mask);
      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 2'(sb.size() != 0), 2'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
